// File: rtl/bfloat_16_multiplier_if.sv
// bfloat_16_multiplier_if: operand strobe/ack handshakes and product strobe
interface bfloat_16_multiplier_if;
  logic [15:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [15:0] input_b;
  logic        input_b_stb;
  logic        input_b_ack;
  logic [15:0] output_z;
  logic        output_z_stb;
  modport master (
    output input_a, input_a_stb, input_b, input_b_stb,
    input  input_a_ack, input_b_ack, output_z, output_z_stb
  );
  modport slave (
    input  input_a, input_a_stb, input_b, input_b_stb,
    output input_a_ack, input_b_ack, output_z, output_z_stb
  );
endinterface

// File: rtl/bfloat_16_multiplier.sv
// bfloat_16_multiplier: multi-cycle bfloat16 multiply with specials, denormals and round-to-nearest-even
module bfloat_16_multiplier (
  input logic clk,
  input logic rst,
  bfloat_16_multiplier_if.slave bus
);
  typedef enum logic [3:0] {
    get_a, get_b, unpack, special, norm_a, norm_b, mul_0, mul_1,
    normalise_1, normalise_2, round, pack, put_z
  } state_t;
  state_t r_state, w_next;
  logic [15:0] r_a, r_b, r_z, r_out_z, r_prod;
  logic [7:0] r_a_m, r_b_m, r_z_m;
  logic signed [9:0] r_a_e, r_b_e, r_z_e;
  logic r_a_s, r_b_s, r_z_s, r_guard, r_round, r_sticky;
  logic r_a_ack, r_b_ack, r_out_stb;
  logic w_a_take, w_b_take;
  logic w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_special, w_round_up;
  logic [15:0] w_special_z, w_z_packed;
  logic [7:0] w_exp;
  assign w_a_take = r_a_ack && bus.input_a_stb;
  assign w_b_take = r_b_ack && bus.input_b_stb;
  assign w_a_nan = r_a_e == 10'sd128 && r_a_m != 8'd0;
  assign w_b_nan = r_b_e == 10'sd128 && r_b_m != 8'd0;
  assign w_a_inf = r_a_e == 10'sd128 && r_a_m == 8'd0;
  assign w_b_inf = r_b_e == 10'sd128 && r_b_m == 8'd0;
  assign w_a_zero = r_a_e == -10'sd127 && r_a_m == 8'd0;
  assign w_b_zero = r_b_e == -10'sd127 && r_b_m == 8'd0;
  assign w_special = w_a_nan || w_b_nan || w_a_inf || w_b_inf || w_a_zero || w_b_zero;
  assign w_special_z = (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) ? 16'hFFC0 :
                       (w_a_inf || w_b_inf) ? {r_a_s ^ r_b_s, 8'hFF, 7'h0} : {r_a_s ^ r_b_s, 15'h0};
  assign w_round_up = r_guard && (r_round || r_sticky || r_z_m[0]);
  assign w_exp = (r_z_e == -10'sd126 && !r_z_m[7]) ? 8'h00 : r_z_e[7:0] + 8'd127;
  assign w_z_packed = (r_z_e > 10'sd127) ? {r_z_s, 8'hFF, 7'h0} : {r_z_s, w_exp, r_z_m[6:0]};
  assign bus.input_a_ack = r_a_ack;
  assign bus.input_b_ack = r_b_ack;
  assign bus.output_z = r_out_z;
  assign bus.output_z_stb = r_out_stb;
  always_ff @(posedge clk)
    r_state <= rst ? get_a : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      get_a:       w_next = w_a_take ? get_b : get_a;
      get_b:       w_next = w_b_take ? unpack : get_b;
      unpack:      w_next = special;
      special:     w_next = w_special ? put_z : norm_a;
      norm_a:      w_next = r_a_m[7] ? norm_b : norm_a;
      norm_b:      w_next = r_b_m[7] ? mul_0 : norm_b;
      mul_0:       w_next = mul_1;
      mul_1:       w_next = normalise_1;
      normalise_1: w_next = r_z_m[7] ? normalise_2 : normalise_1;
      normalise_2: w_next = (r_z_e >= -10'sd126) ? round : normalise_2;
      round:       w_next = pack;
      pack:        w_next = put_z;
      put_z:       w_next = r_out_stb ? get_a : put_z;
      default:     w_next = get_a;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      r_out_stb <= 1'b0;
      r_out_z <= 16'h0000;
    end else begin
      case (r_state)
        get_a: begin
          r_a_ack <= !w_a_take;
          if (w_a_take) r_a <= bus.input_a;
        end
        get_b: begin
          r_b_ack <= !w_b_take;
          if (w_b_take) r_b <= bus.input_b;
        end
        unpack: begin
          r_a_m <= {1'b0, r_a[6:0]};
          r_b_m <= {1'b0, r_b[6:0]};
          r_a_e <= $signed({2'b00, r_a[14:7]}) - 10'sd127;
          r_b_e <= $signed({2'b00, r_b[14:7]}) - 10'sd127;
          r_a_s <= r_a[15];
          r_b_s <= r_b[15];
        end
        special: begin
          if (w_special) r_z <= w_special_z;
          else begin
            if (r_a_e == -10'sd127) r_a_e <= -10'sd126;
            else r_a_m[7] <= 1'b1;
            if (r_b_e == -10'sd127) r_b_e <= -10'sd126;
            else r_b_m[7] <= 1'b1;
          end
        end
        norm_a: if (!r_a_m[7]) begin
          r_a_m <= r_a_m << 1;
          r_a_e <= r_a_e - 10'sd1;
        end
        norm_b: if (!r_b_m[7]) begin
          r_b_m <= r_b_m << 1;
          r_b_e <= r_b_e - 10'sd1;
        end
        mul_0: begin
          r_z_s <= r_a_s ^ r_b_s;
          r_z_e <= r_a_e + r_b_e + 10'sd1;
          r_prod <= r_a_m * r_b_m;
        end
        mul_1: begin
          r_z_m <= r_prod[15:8];
          r_guard <= r_prod[7];
          r_round <= r_prod[6];
          r_sticky <= |r_prod[5:0];
        end
        normalise_1: if (!r_z_m[7]) begin
          r_z_e <= r_z_e - 10'sd1;
          r_z_m <= {r_z_m[6:0], r_guard};
          r_guard <= r_round;
          r_round <= 1'b0;
        end
        normalise_2: if (r_z_e < -10'sd126) begin
          r_z_e <= r_z_e + 10'sd1;
          r_z_m <= r_z_m >> 1;
          r_guard <= r_z_m[0];
          r_round <= r_guard;
          r_sticky <= r_sticky || r_round;
        end
        round: if (w_round_up) begin
          r_z_m <= r_z_m + 8'd1;
          if (r_z_m == 8'hFF) r_z_e <= r_z_e + 10'sd1;
        end
        pack: r_z <= w_z_packed;
        put_z: begin
          r_out_stb <= !r_out_stb;
          if (!r_out_stb) r_out_z <= r_z;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bfloat_16_multiplier.sv
// tb_bfloat_16_multiplier: directed and random products checked against an exact-arithmetic bfloat16 model
module tb_bfloat_16_multiplier;
  logic clk, rst;
  bfloat_16_multiplier_if bus();
  bfloat_16_multiplier dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct { logic [15:0] z; int lat; } exp_t;
  exp_t exp_q[$];
  int cap_q[$];
  int n_cmp = 0, n_fail = 0, cyc = 0, cap;
  logic [15:0] last_z = 16'h0;
  logic prev_stb = 1'b0;
  exp_t e;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endfunction
  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
    int ea = int'(a[14:7]), eb = int'(b[14:7]), fa = int'(a[6:0]), fb = int'(b[6:0]);
    logic s = a[15] ^ b[15];
    bit na = ea == 255 && fa != 0, nb = eb == 255 && fb != 0;
    bit ia = ea == 255 && fa == 0, ib = eb == 255 && fb == 0;
    bit za = ea == 0 && fa == 0, zb = eb == 0 && fb == 0;
    int m, x, n, qe, sh, q, rem, half;
    if (na || nb || (ia && zb) || (ib && za)) return 16'hFFC0;
    if (ia || ib) return {s, 8'hFF, 7'h0};
    if (za || zb) return {s, 15'h0};
    m = (ea == 0 ? fa : fa + 128) * (eb == 0 ? fb : fb + 128);
    x = (ea == 0 ? 1 : ea) + (eb == 0 ? 1 : eb) - 268;
    n = 0;
    while ((m >> n) != 0) n++;
    qe = (x + n - 1 < -126) ? -133 : x + n - 8;
    sh = qe - x;
    if (sh <= 0) q = m << -sh;
    else if (sh > 20) q = 0;
    else begin
      q = m >> sh;
      rem = m - (q << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && q % 2 == 1)) q++;
    end
    if (q == 256) begin q = 128; qe++; end
    if (q < 128) return {s, 8'h00, 7'(q)};
    if (qe + 134 >= 255) return {s, 8'hFF, 7'h0};
    return {s, 8'(qe + 134), 7'(q)};
  endfunction
  function automatic logic [15:0] rnd_bf();
    int k = $urandom_range(0, 9);
    logic [7:0] ex = k == 0 ? 8'd0 : k == 1 ? 8'd255 : k == 2 ? 8'($urandom_range(1, 3)) :
                     k == 3 ? 8'($urandom_range(250, 254)) : 8'($urandom_range(100, 154));
    logic [6:0] fr = ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom);
    return {1'($urandom), ex, fr};
  endfunction
  task automatic xfer(input bit is_b, input logic [15:0] d);
    int t = 0;
    if (is_b) begin bus.input_b = d; bus.input_b_stb = 1'b1; end
    else begin bus.input_a = d; bus.input_a_stb = 1'b1; end
    do begin @(negedge clk); t++; end while (!(is_b ? bus.input_b_ack : bus.input_a_ack) && t < 500);
    chk(is_b ? "b_ack_wait" : "a_ack_wait", {31'b0, t < 500}, 1);
    @(posedge clk); #1;
    if (is_b) bus.input_b_stb = 1'b0; else bus.input_a_stb = 1'b0;
  endtask
  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [15:0] z, input int lat);
    exp_q.push_back('{z, lat});
    xfer(0, a);
    xfer(1, b);
  endtask
  always @(posedge clk) begin
    if (!rst && bus.input_b_stb && bus.input_b_ack) cap_q.push_back(cyc);
    cyc++;
  end
  always @(negedge clk) begin
    if (rst) last_z = 16'h0;
    else if (bus.output_z_stb) begin
      chk("stb_single_cycle", {31'b0, prev_stb}, 0);
      chk("stb_expected", {31'b0, exp_q.size() != 0 && cap_q.size() != 0}, 1);
      if (exp_q.size() != 0 && cap_q.size() != 0) begin
        e = exp_q.pop_front();
        cap = cap_q.pop_front();
        chk("product", {16'h0, bus.output_z}, {16'h0, e.z});
        if (e.lat >= 0) chk("latency", cyc - cap - 1, e.lat);
      end
      last_z = bus.output_z;
    end else chk("z_hold", {16'h0, bus.output_z}, {16'h0, last_z});
    prev_stb = bus.output_z_stb && !rst;
  end
  logic [15:0] da [12] = '{16'h3FC0, 16'hBFC0, 16'h3F81, 16'h3F81, 16'h7F80, 16'h7F80, 16'h7FC1,
                           16'h8000, 16'h7F00, 16'h0040, 16'h0080, 16'h3FC0};
  logic [15:0] db [12] = '{16'h3FC0, 16'h3FC0, 16'h4040, 16'h3F81, 16'h0000, 16'hC000, 16'h3F80,
                           16'h3F80, 16'h4000, 16'h3F80, 16'h3F00, 16'h4000};
  logic [15:0] dz [12] = '{16'h4010, 16'hC010, 16'h4042, 16'h3F82, 16'hFFC0, 16'hFF80, 16'hFFC0,
                           16'h8000, 16'h7F80, 16'h0040, 16'h0040, 16'h4040};
  int dl [12] = '{11, 11, -1, -1, 3, 3, 3, 3, -1, -1, -1, -1};
  initial begin
    logic [15:0] ra, rb;
    int t;
    rst = 1'b1;
    bus.input_a = 16'h0; bus.input_b = 16'h0;
    bus.input_a_stb = 1'b0; bus.input_b_stb = 1'b0;
    chk("model_tie", {16'h0, model(16'h3F81, 16'h4040)}, 32'h4042);
    chk("model_sticky", {16'h0, model(16'h3F81, 16'h3F81)}, 32'h3F82);
    chk("model_to_denormal", {16'h0, model(16'h0080, 16'h3F00)}, 32'h0040);
    chk("model_overflow", {16'h0, model(16'h7F00, 16'h4000)}, 32'h7F80);
    chk("model_basic", {16'h0, model(16'h3FC0, 16'h4000)}, 32'h4040);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ack", {31'b0, bus.input_a_ack}, 0);
    chk("rst_b_ack", {31'b0, bus.input_b_ack}, 0);
    chk("rst_z_stb", {31'b0, bus.output_z_stb}, 0);
    chk("rst_z", {16'h0, bus.output_z}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.input_a = 16'h3FC0;
    bus.input_a_stb = 1'b1;
    exp_q.push_back('{16'h4040, -1});
    @(negedge clk);
    chk("a_ack_before_first_edge", {31'b0, bus.input_a_ack}, 0);
    @(negedge clk);
    chk("a_ack_after_first_edge", {31'b0, bus.input_a_ack}, 1);
    @(negedge clk);
    chk("a_ack_dropped_on_capture", {31'b0, bus.input_a_ack}, 0);
    bus.input_a_stb = 1'b0;
    xfer(1, 16'h4000);
    for (int i = 0; i < 12; i++) run(da[i], db[i], dz[i], dl[i]);
    xfer(0, 16'h3FC0);
    xfer(1, 16'h4000);
    exp_q.push_back('{16'h4040, -1});
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    cap_q.delete();
    @(negedge clk);
    chk("midrst_a_ack", {31'b0, bus.input_a_ack}, 0);
    chk("midrst_b_ack", {31'b0, bus.input_b_ack}, 0);
    chk("midrst_z_stb", {31'b0, bus.output_z_stb}, 0);
    chk("midrst_z", {16'h0, bus.output_z}, 0);
    run(16'h3FC0, 16'h3FC0, 16'h4010, 11);
    for (int i = 0; i < 150; i++) begin
      ra = rnd_bf();
      rb = rnd_bf();
      run(ra, rb, model(ra, rb), -1);
    end
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    chk("drain", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
